// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding, HALT marker
// and the byte-per-word packing factor.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [5:0]  HALT_OPCODE       = 6'b111111;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD    = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs bytes MSB-first into a 32-bit word; last_byte flags that the next
// accepted byte completes the word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  // clear wins over shift so a restart never keeps residue from an old load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clear) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (shift_en) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= {word_q[23:0], byte_in};
    end
  end

  assign word      = word_q;
  assign last_byte = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Program loader: packs a byte stream into 32-bit instruction words and writes
// them to consecutive instruction-memory addresses until HALT or memory full.
module instr_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count,
  output logic [2:0]        o_state
);

  // Handshake: a byte transfers on a rising edge where i_byte_valid and
  // o_byte_ready are both high; the source holds i_byte stable until then.

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              asm_clear, asm_shift, last_byte;
  logic [31:0]       word;

  word_assembler u_asm (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (i_byte),
    .word      (word),
    .last_byte (last_byte)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    asm_clear = 1'b0;
    asm_shift = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          state_d   = S_RECV;
          addr_d    = '0;
          count_d   = '0;
          asm_clear = 1'b1;
        end
      end
      S_RECV: begin
        if (i_byte_valid) begin
          asm_shift = 1'b1;
          if (last_byte) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        // HALT is checked first so a HALT in the top slot still ends as DONE
        if (word == HALT_WORD)            state_d = S_DONE;
        else if (addr_q == {ADDR_W{1'b1}}) state_d = S_ERR;
        else begin
          state_d = S_RECV;
          addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_byte_ready = (state_q == S_RECV);
  assign o_mem_we     = (state_q == S_WRITE);
  assign o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_done       = (state_q == S_DONE);
  assign o_overflow   = (state_q == S_ERR);
  assign o_mem_addr   = addr_q;
  assign o_mem_data   = word;
  assign o_word_count = count_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader with a 4-word memory: directed byte streams, an
// expected-write queue and a monitor that checks every memory write.
module tb_instr_loader;

  localparam int AW = 2;
  localparam int W  = AW + 32;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_RECV = 3'd1, ST_DONE = 3'd3, ST_ERR = 3'd4;

  logic          clk, rst_n, start, byte_valid;
  logic [7:0]    byte_in;
  logic          byte_ready, mem_we, busy, done, overflow;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [AW:0]   word_count;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  instr_loader #(.ADDR_W(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_byte       (byte_in),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_word_count (word_count),
    .o_state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          bad++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_data, e[W-1:32], e[31:0]);
        end
      end
    end
  end

  // drivers
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_flags", {busy, done, overflow}, 0);
    chk("rst_regs", {mem_addr, mem_data, word_count}, 0);
    chk("rst_state", state, ST_IDLE);
    byte_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      byte_in = b;
      byte_valid = 1'b1;
      rdy = byte_ready;
      @(posedge clk);
      n++;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: byte %0h not accepted in 50 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 0);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int n;
    n = 0;
    while (state !== st && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, state, st);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    // idle ignores bytes until started
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_ready", byte_ready, 0);
    chk("idle_state", state, ST_IDLE);
    byte_valid = 1'b0;

    // single word, back to back, with exact latency
    pulse_start();
    chk("start_busy", busy, 1);
    exp_q.push_back({2'd0, 32'h2001_0005});
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    #1;
    chk("lat_we", mem_we, 1);
    chk("lat_ready_low", byte_ready, 0);
    chk("lat_count_before", word_count, 0);
    @(posedge clk);
    #1;
    chk("lat_count_after", word_count, 1);
    chk("lat_ready_back", byte_ready, 1);
    chk("lat_we_low", mem_we, 0);
    bus_idle();

    // gapped valid
    @(negedge clk);
    do_reset();
    pulse_start();
    exp_q.push_back({2'd0, 32'h2001_0005});
    send_byte(8'h20, 3);
    send_byte(8'h01, 0);
    send_byte(8'h00, 2);
    send_byte(8'h05, 1);
    bus_idle();
    @(negedge clk);
    chk("gap_count", word_count, 1);
    chk("gap_state", state, ST_RECV);

    // HALT termination; bytes driven during WRITE wait for ready
    do_reset();
    pulse_start();
    exp_q.push_back({2'd0, 32'h2001_0005});
    exp_q.push_back({2'd1, 32'h0022_1820});
    exp_q.push_back({2'd2, 32'hFFFF_FFFF});
    send_word(32'h2001_0005);
    send_word(32'h0022_1820);
    send_word(32'hFFFF_FFFF);
    bus_idle();
    wait_state(ST_DONE, "halt_state");
    chk("halt_done", done, 1);
    chk("halt_count", word_count, 3);
    chk("halt_ready", byte_ready, 0);
    chk("halt_ovf", overflow, 0);
    byte_valid = 1'b1;
    byte_in = 8'h77;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    chk("halt_hold", {done, word_count, state}, {1'b1, 3'd3, ST_DONE});

    // overflow with a 4-word memory
    do_reset();
    pulse_start();
    exp_q.push_back({2'd0, 32'h1122_3344});
    exp_q.push_back({2'd1, 32'h5566_7788});
    exp_q.push_back({2'd2, 32'h0000_0000});
    exp_q.push_back({2'd3, 32'h0102_0304});
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    send_word(32'h0000_0000);
    send_word(32'h0102_0304);
    bus_idle();
    wait_state(ST_ERR, "ovf_state");
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", word_count, 4);
    chk("ovf_done", done, 0);
    chk("ovf_addr", mem_addr, 3);
    pulse_start();
    chk("restart_clear", {overflow, word_count, mem_addr}, 0);
    exp_q.push_back({2'd0, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF);
    bus_idle();
    @(negedge clk);
    chk("restart_count", word_count, 1);

    // abort mid-word by reset, then a clean load
    do_reset();
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    #1;
    do_reset();
    @(negedge clk);
    chk("abort_idle", {state, byte_ready}, {ST_IDLE, 1'b0});
    pulse_start();
    exp_q.push_back({2'd0, 32'hAABB_CCDD});
    send_word(32'hAABB_CCDD);
    bus_idle();
    @(negedge clk);
    chk("abort_count", word_count, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
